// File: rtl/life_grid_ctrl_if.sv
// Host-side bundle for life_grid_ctrl: step control, row load/read port and status.
interface life_grid_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int GEN_W  = 16
);
  localparam int RW = $clog2(HEIGHT);
  localparam int PW = $clog2(WIDTH*HEIGHT+1);

  logic             start;
  logic             wr_en;
  logic [RW-1:0]    wr_row;
  logic [WIDTH-1:0] wr_data;
  logic [RW-1:0]    rd_row;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] gen;
  logic [PW-1:0]    pop;

  modport master (
    output start, wr_en, wr_row, wr_data, rd_row,
    input  rd_data, busy, done, gen, pop
  );

  modport slave (
    input  start, wr_en, wr_row, wr_data, rd_row,
    output rd_data, busy, done, gen, pop
  );
endinterface

// File: rtl/life_grid_ctrl.sv
// Row-serial Conway Life sequencer: next generation built in a shadow grid, then committed at once.
// Define LIFE_TORUS_EN to wrap grid edges; otherwise cells beyond the edge read as dead.
module life_grid_ctrl #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int GEN_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  life_grid_ctrl_if.slave bus
);
  localparam int RW = $clog2(HEIGHT);
  localparam int PW = $clog2(WIDTH*HEIGHT+1);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT-1);
`ifdef LIFE_TORUS_EN
  localparam bit TORUS = 1'b1;
`else
  localparam bit TORUS = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    pop_q, pop_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] cur_q [HEIGHT];
  logic [WIDTH-1:0] cur_d [HEIGHT];
  logic [WIDTH-1:0] nxt_q [HEIGHT];
  logic [WIDTH-1:0] nxt_d [HEIGHT];
  logic [RW-1:0]    row_up_s, row_dn_s;
  logic [WIDTH-1:0] above_s, below_s, new_row_s;

  function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s = s + PW'(v[i]);
    end
    return s;
  endfunction

  // Padded rows put column -1 at bit 0 and column WIDTH at bit WIDTH+1.
  function automatic logic [WIDTH-1:0] life_row(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] m,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH+1:0] ea, em, eb;
    logic [3:0]       n;
    logic [WIDTH-1:0] res;
    ea = {(TORUS ? a[0] : 1'b0), a, (TORUS ? a[WIDTH-1] : 1'b0)};
    em = {(TORUS ? m[0] : 1'b0), m, (TORUS ? m[WIDTH-1] : 1'b0)};
    eb = {(TORUS ? b[0] : 1'b0), b, (TORUS ? b[WIDTH-1] : 1'b0)};
    for (int c = 0; c < WIDTH; c++) begin
      n = 4'(ea[c]) + 4'(ea[c+1]) + 4'(ea[c+2]) + 4'(em[c]) + 4'(em[c+2])
        + 4'(eb[c]) + 4'(eb[c+1]) + 4'(eb[c+2]);
      res[c] = (n == 4'd3) || (em[c+1] && (n == 4'd2));
    end
    return res;
  endfunction

  // Neighbour rows of the row under evaluation, always taken from the committed grid.
  always_comb begin
    row_up_s = (row_q == '0) ? LAST_ROW : row_q - RW'(1);
    row_dn_s = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
    if ((row_q == '0) && (TORUS == 1'b0)) begin
      above_s = '0;
    end else begin
      above_s = cur_q[row_up_s];
    end
    if ((row_q == LAST_ROW) && (TORUS == 1'b0)) begin
      below_s = '0;
    end else begin
      below_s = cur_q[row_dn_s];
    end
    new_row_s = life_row(above_s, cur_q[row_q], below_s);
  end

  // Sequencer next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    acc_d   = acc_q;
    gen_d   = gen_q;
    pop_d   = pop_q;
    done_d  = 1'b0;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.wr_en) begin
          cur_d[bus.wr_row] = bus.wr_data;
        end else begin
          cur_d = cur_q;
        end
        if (bus.start) begin
          state_d = S_CALC;
          row_d   = '0;
          acc_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        nxt_d[row_q] = new_row_s;
        acc_d        = acc_q + popcount(new_row_s);
        if (row_q == LAST_ROW) begin
          state_d = S_COMMIT;
          row_d   = row_q;
        end else begin
          state_d = S_CALC;
          row_d   = row_q + RW'(1);
        end
      end
      S_COMMIT: begin
        cur_d   = nxt_q;
        gen_d   = gen_q + GEN_W'(1);
        pop_d   = acc_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and grid registers; reset aborts any step in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      acc_q   <= '0;
      gen_q   <= '0;
      pop_q   <= '0;
      done_q  <= 1'b0;
      cur_q   <= '{default: '0};
      nxt_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      gen_q   <= gen_d;
      pop_q   <= pop_d;
      done_q  <= done_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
    end
  end

  assign bus.rd_data = cur_q[bus.rd_row];
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.gen     = gen_q;
  assign bus.pop     = pop_q;
endmodule

// File: tb/tb_life_grid_ctrl.sv
// Randomized bench for life_grid_ctrl against a cell-by-cell Life reference model.
module tb_life_grid_ctrl;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int GW = 16;
  localparam int RW = $clog2(H);
`ifdef LIFE_TORUS_EN
  localparam bit TORUS = 1'b1;
`else
  localparam bit TORUS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  life_grid_ctrl_if #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW)) bus ();
  life_grid_ctrl #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW)) dut (.clk(clk), .rst(rst), .bus(bus));

  life_grid_ctrl_if #(.WIDTH(W), .HEIGHT(H), .GEN_W(2)) bus2 ();
  life_grid_ctrl #(.WIDTH(W), .HEIGHT(H), .GEN_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] mgrid [H];
  int mpop = 0;
  int mgen = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: count the eight neighbours of every cell directly.
  task automatic model_step();
    logic [W-1:0] nx [H];
    int cnt, rr, cc;
    mpop = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (TORUS) begin
              rr = (rr + H) % H;
              cc = (cc + W) % W;
            end
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < H && cc >= 0 && cc < W)
              cnt += int'(mgrid[rr][cc]);
          end
        end
        nx[r][c] = (cnt == 3) || (mgrid[r][c] && cnt == 2);
        mpop += int'(nx[r][c]);
      end
    end
    for (int r = 0; r < H; r++) mgrid[r] = nx[r];
    mgen++;
  endtask

  task automatic check_grid(input string tag);
    for (int r = 0; r < H; r++) begin
      bus.rd_row = RW'(r);
      #1;
      check_eq($sformatf("%s_row%0d", tag, r), 64'(bus.rd_data), 64'(mgrid[r]));
      @(negedge clk);
    end
  endtask

  task automatic write_row(input int row, input logic [W-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_row  = RW'(row);
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
    mgrid[row] = data;
    check_eq("pop_after_wr", 64'(bus.pop), 64'(mpop));
  endtask

  // One generation; entered and left on a falling edge.
  task automatic do_step(input bit disturb, input bit b2b, input bit wr_at_start,
                         input int wrow, input logic [W-1:0] wdata);
    bus.start = 1'b1;
    if (wr_at_start) begin
      bus.wr_en   = 1'b1;
      bus.wr_row  = RW'(wrow);
      bus.wr_data = wdata;
      mgrid[wrow] = wdata;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    check_eq("busy_after_start", 64'(bus.busy), 64'd1);
    check_eq("done_width", 64'(bus.done), 64'd0);
    for (int cyc = 1; cyc <= H + 1; cyc++) begin
      if (disturb && cyc == 3) begin
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_row  = '0;
        bus.wr_data = 8'hFF;
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      if (cyc <= H) begin
        check_eq("no_early_done", 64'(bus.done), 64'd0);
        check_eq("busy_in_step", 64'(bus.busy), 64'd1);
      end
    end
    model_step();
    check_eq("done_at_end", 64'(bus.done), 64'd1);
    check_eq("busy_at_end", 64'(bus.busy), 64'd0);
    check_eq("gen", 64'(bus.gen), 64'(mgen % 65536));
    check_eq("pop", 64'(bus.pop), 64'(mpop));
    if (!b2b) begin
      @(negedge clk);
      check_eq("done_drop", 64'(bus.done), 64'd0);
      check_grid("grid");
    end
  endtask

  initial begin
    int dcount;
    bus.start = 1'b0; bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_data = '0; bus.rd_row = '0;
    bus2.start = 1'b0; bus2.wr_en = 1'b0; bus2.wr_row = '0; bus2.wr_data = '0; bus2.rd_row = '0;
    for (int r = 0; r < H; r++) mgrid[r] = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_gen", 64'(bus.gen), 64'd0);
    check_eq("rst_pop", 64'(bus.pop), 64'd0);
    check_grid("rst");
    rst = 1'b0;
    @(negedge clk);

    // Blinker: oscillates with period two.
    write_row(3, 8'h1C);
    do_step(1'b0, 1'b0, 1'b0, 0, '0);
    bus.rd_row = RW'(3);
    #1 check_eq("t1_row3", 64'(bus.rd_data), 64'h08);
    check_eq("t1_pop", 64'(bus.pop), 64'd3);
    @(negedge clk);
    do_step(1'b0, 1'b0, 1'b0, 0, '0);
    bus.rd_row = RW'(3);
    #1 check_eq("t1_row3_back", 64'(bus.rd_data), 64'h1C);
    @(negedge clk);

    // Block still life, mid-step disturbance ignored.
    write_row(3, 8'h00);
    write_row(3, 8'h18);
    write_row(4, 8'h18);
    do_step(1'b1, 1'b0, 1'b0, 0, '0);
    check_eq("t2_pop", 64'(bus.pop), 64'd4);

    // Random grids, mixing back-to-back starts and writes coinciding with start.
    for (int t = 0; t < 5; t++) begin
      for (int r = 0; r < H; r++) write_row(r, W'($urandom));
      do_step(1'b0, 1'b1, 1'b0, 0, '0);
      do_step(($urandom_range(0, 1) == 1), 1'b0, 1'b1, $urandom_range(0, H - 1), W'($urandom));
      do_step(1'b1, 1'b0, ($urandom_range(0, 1) == 1), $urandom_range(0, H - 1), W'($urandom));
    end

    // Reset in the middle of a step.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
    check_eq("mid_rst_done", 64'(bus.done), 64'd0);
    check_eq("mid_rst_gen", 64'(bus.gen), 64'd0);
    check_eq("mid_rst_pop", 64'(bus.pop), 64'd0);
    for (int r = 0; r < H; r++) mgrid[r] = '0;
    mpop = 0;
    mgen = 0;
    @(negedge clk);
    check_grid("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    do_step(1'b0, 1'b0, 1'b0, 0, '0);

    // Narrow generation counter wraps; done must pulse once per step.
    bus2.wr_en   = 1'b1;
    bus2.wr_row  = RW'(3);
    bus2.wr_data = 8'h1C;
    @(negedge clk);
    bus2.wr_en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      bus2.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      dcount = 0;
      repeat (H + 2) begin
        @(negedge clk);
        if (bus2.done) dcount++;
      end
      check_eq($sformatf("gw2_done_count%0d", k), 64'(dcount), 64'd1);
      check_eq($sformatf("gw2_gen%0d", k), 64'(bus2.gen), 64'(k % 4));
      check_eq($sformatf("gw2_pop%0d", k), 64'(bus2.pop), 64'd3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
